// File: rtl/scpu_mem_arbiter.sv
// scpu_mem_arbiter: round-robin arbiter giving NUM_PORTS requesters access to one internal synchronous data memory.
// Optional MEM_INIT_CLEAR_EN: zero the whole array after reset, holding busy high until it is done.
module scpu_mem_arbiter #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8192,
    parameter int NUM_PORTS = 2,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        wen_n,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        gnt,
    output logic [NUM_PORTS-1:0]        rvalid,
    output logic [DATA_W-1:0]           rdata,
    output logic                        busy
);
    localparam int PW = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
    localparam int MW = DEPTH > 1 ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     sel;
    logic              hit;
    logic [ADDR_W-1:0] sel_addr;
    logic [MW-1:0]     idx;
    logic              in_range;
    logic              wr;
    logic              rd;
    logic [DATA_W-1:0] rd_word;

    logic              pv  [RD_LAT];
    logic [PW-1:0]     pid [RD_LAT];
    logic [DATA_W-1:0] pd  [RD_LAT];

    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int i;
            i = (int'(rr_ptr) + k) % NUM_PORTS;
            if (!hit && req[i] && !busy) begin
                hit = 1'b1;
                sel = PW'(i);
            end
        end
        gnt = '0;
        gnt[sel] = hit;
    end

    assign sel_addr = addr[int'(sel)*ADDR_W +: ADDR_W];
    assign idx      = sel_addr[MW-1:0];
    assign in_range = 32'(sel_addr) < DEPTH;
    assign wr       = hit & ~wen_n[sel];
    assign rd       = hit & wen_n[sel];
    assign rd_word  = in_range ? mem[idx] : '0;

    // data registers only load on a valid entry so rdata holds between returns
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                pv[s]  <= 1'b0;
                pid[s] <= '0;
                pd[s]  <= '0;
            end
        end else begin
            if (hit) rr_ptr <= PW'((int'(sel) + 1) % NUM_PORTS);
            pv[0]  <= rd;
            pid[0] <= sel;
            if (rd) pd[0] <= rd_word;
            for (int s = 1; s < RD_LAT; s++) begin
                pv[s]  <= pv[s-1];
                pid[s] <= pid[s-1];
                if (pv[s-1]) pd[s] <= pd[s-1];
            end
        end
    end

    assign rvalid = pv[RD_LAT-1] ? NUM_PORTS'(1) << pid[RD_LAT-1] : '0;
    assign rdata  = pd[RD_LAT-1];

`ifdef MEM_INIT_CLEAR_EN
    typedef enum logic {CLEAR, READY} state_t;
    state_t        state, state_nx;
    logic [MW-1:0] clr_cnt, cnt_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = clr_cnt;
        if (state == CLEAR) begin
            cnt_nx = clr_cnt + 1'b1;
            if (clr_cnt == MW'(DEPTH - 1)) state_nx = READY;
        end
    end

    assign busy = state == CLEAR;

    always_ff @(posedge clk) begin
        if (busy) mem[clr_cnt] <= '0;
        else if (wr && in_range) mem[idx] <= wdata[int'(sel)*DATA_W +: DATA_W];
    end
`else
    assign busy = 1'b0;

    always_ff @(posedge clk) begin
        if (wr && in_range) mem[idx] <= wdata[int'(sel)*DATA_W +: DATA_W];
    end
`endif
endmodule

// File: tb/tb_scpu_mem_arbiter.sv
// tb_scpu_mem_arbiter: randomized and directed checks of scpu_mem_arbiter against a transaction-level model.
module tb_scpu_mem_arbiter;
    localparam int DW = 16, AW = 13, DEPTH = 4096, NP = 2, LAT = 3;
`ifdef MEM_INIT_CLEAR_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NP-1:0]     req, wen_n, gnt, rvalid;
    logic [NP*AW-1:0]  addr;
    logic [NP*DW-1:0]  wdata;
    logic [DW-1:0]     rdata;
    logic              busy;

    scpu_mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .NUM_PORTS(NP), .RD_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wen_n(wen_n), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {int due; int port; logic [DW-1:0] d;} ret_t;

    int            n_chk = 0, n_fail = 0, cyc = 0, m_ptr = 0;
    bit            pq [NP];
    bit            pw [NP];
    int            pa [NP];
    logic [DW-1:0] pd [NP];
    logic [DW-1:0] m_mem [DEPTH];
    bit            known [DEPTH];
    ret_t          q [$];
    logic [DW-1:0] last_rd = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NP; i++) begin
            req[i]               = pq[i];
            wen_n[i]             = !pw[i];
            addr[i*AW +: AW]     = AW'(pa[i]);
            wdata[i*DW +: DW]    = pd[i];
        end
    endtask

    // one clock: grant predicted from the round-robin rule, returns from the expected-read queue
    task automatic cycle(output int g);
        logic [NP-1:0] eg, erv;
        eg = '0;
        erv = '0;
        g = -1;
        drive();
        #4;
        for (int k = 0; k < NP; k++) if (g < 0 && pq[(m_ptr + k) % NP]) g = (m_ptr + k) % NP;
        if (g >= 0) eg[g] = 1'b1;
        chk("gnt", gnt, eg);
        chk("busy", busy, 0);
        if (g >= 0) begin
            if (pw[g]) begin
                if (pa[g] < DEPTH) begin
                    m_mem[pa[g]] = pd[g];
                    known[pa[g]] = 1'b1;
                end
            end else q.push_back('{cyc + LAT, g, pa[g] < DEPTH ? m_mem[pa[g]] : '0});
            m_ptr = (g + 1) % NP;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].port] = 1'b1;
            last_rd = q[0].d;
            void'(q.pop_front());
        end
        chk("rvalid", rvalid, erv);
        chk("rdata", rdata, last_rd);
    endtask

    task automatic xfer(input int p, input bit w, input int a, input logic [DW-1:0] d);
        int g, n;
        n = 0;
        pq[p] = 1'b1; pw[p] = w; pa[p] = a; pd[p] = d;
        do begin
            cycle(g);
            n++;
        end while (g != p && n < 20);
        chk("grant_wait", g, p);
        pq[p] = 1'b0;
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < NP; i++) pq[i] = 1'b0;
        repeat (n) cycle(g);
    endtask

    task automatic rst_pulse();
        rst_n = 1'b0;
        for (int i = 0; i < NP; i++) pq[i] = 1'b0;
        drive();
        #1;
        chk("rvalid_rst", rvalid, 0);
        chk("rdata_rst", rdata, 0);
        chk("busy_rst", busy, CLR);
        if (!CLR) chk("gnt_rst", gnt, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        q.delete();
        m_ptr = 0;
        last_rd = '0;
        #1;
`ifdef MEM_INIT_CLEAR_EN
        begin
            int n, bad;
            n = 0;
            bad = 0;
            for (int i = 0; i < NP; i++) begin pq[i] = 1'b1; pw[i] = 1'b0; pa[i] = 7; end
            drive();
            while (busy && n < 2 * DEPTH) begin
                n++;
                if (gnt != '0) bad++;
                @(posedge clk);
                #1;
            end
            chk("clear_len", n, DEPTH);
            chk("clear_gnt_cycles", bad, 0);
            for (int i = 0; i < NP; i++) pq[i] = 1'b0;
            for (int a = 0; a < DEPTH; a++) begin m_mem[a] = '0; known[a] = 1'b1; end
        end
`endif
    endtask

    initial begin
        int g, r;
        for (int i = 0; i < NP; i++) begin pq[i] = 0; pw[i] = 0; pa[i] = 0; pd[i] = '0; end
        drive();
        repeat (2) @(posedge clk);
        #1;
        rst_pulse();
`ifdef MEM_INIT_CLEAR_EN
        xfer(0, 1'b0, 7, '0);
        idle(LAT + 1);
`endif
        xfer(0, 1'b1, 5, 16'h1234);
        xfer(0, 1'b1, 0, 16'hAAAA);
        xfer(1, 1'b1, 1, 16'h5555);
        xfer(0, 1'b0, 5, '0);
        idle(LAT + 1);
        rst_pulse();
        if (!CLR) begin
            pq[0] = 1; pw[0] = 0; pa[0] = 0;
            pq[1] = 1; pw[1] = 0; pa[1] = 1;
            repeat (4) cycle(g);
            idle(LAT + 1);
        end
        xfer(1, 1'b1, 100, 16'hFFFE);
        xfer(1, 1'b0, 100, '0);
        idle(LAT + 1);
        xfer(0, 1'b1, DEPTH, 16'h7777);
        xfer(0, 1'b0, DEPTH, '0);
        xfer(1, 1'b0, 0, '0);
        idle(LAT + 1);
        pq[0] = 1; pw[0] = 0; pa[0] = 5;
        repeat (3) cycle(g);
        rst_pulse();
        idle(LAT + 3);
        pq[0] = 1; pw[0] = 0; pa[0] = 100;
        pq[1] = 1; pw[1] = 0; pa[1] = 5;
        repeat (2) cycle(g);
        idle(LAT + 1);
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pq[i] && $urandom_range(0, 2) != 0) begin
                    pq[i] = 1'b1;
                    r = $urandom_range(0, 9);
                    pa[i] = r < 7 ? $urandom_range(0, 15) : r < 8 ? 100 : $urandom_range(DEPTH, 8191);
                    pw[i] = $urandom_range(0, 2) == 0;
                    if (pa[i] < DEPTH && !known[pa[i]]) pw[i] = 1'b1;
                    pd[i] = DW'($urandom);
                end
            end
            cycle(g);
            if (g >= 0) pq[g] = 1'b0;
            if (c == 300) rst_pulse();
        end
        idle(LAT + 2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
